// File: rtl/rr_shi_ctrl.sv
// Load/shift sequencer for the 256-bit right-shift register of the modular divider.
// Define RR_SHI_CTRL_STRIP_EN to enable the strip-trailing-zeros command (op 01).
module rr_shi_ctrl #(
  parameter int WORDS = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic             reg_lsb,
  input  logic             reg_zero,
  output logic             reg_we,
  output logic             reg_sel_rs,
  output logic [15:0]      reg_din,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             cmd_err
);

  localparam int WC_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_SHIFT, S_STRIP} state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic             cmd_err_q, cmd_err_d;
  logic             done_q, done_d;
  logic             load_fire, cmd_fire, strip_step;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign cmd_ready = (state_q == S_HOLD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_STRIP);
  assign load_fire = in_valid & in_ready;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign done      = done_q;
  assign shift_cnt = shift_cnt_q;
  assign cmd_err   = cmd_err_q;

`ifdef RR_SHI_CTRL_STRIP_EN
  // A strip keeps shifting while the LSB is zero, capped at the counter maximum.
  assign strip_step = (state_q == S_STRIP) && !reg_lsb && (shift_cnt_q != CNT_MAX);
`else
  logic unused_strip_inputs;
  assign strip_step          = 1'b0;
  assign unused_strip_inputs = reg_lsb ^ reg_zero;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      remain_q    <= '0;
      shift_cnt_q <= '0;
      cmd_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      remain_q    <= remain_d;
      shift_cnt_q <= shift_cnt_d;
      cmd_err_q   <= cmd_err_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    remain_d    = remain_q;
    shift_cnt_d = shift_cnt_q;
    cmd_err_d   = cmd_err_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (load_fire) begin
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            state_d    = S_HOLD;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = S_LOAD;
          end
        end
      end
      S_HOLD: begin
        if (cmd_fire) begin
          shift_cnt_d = '0;
          cmd_err_d   = 1'b0;
          case (cmd_op)
            2'b00: begin
              if (cmd_amt == '0) begin
                done_d = 1'b1;
              end else begin
                remain_d = cmd_amt;
                state_d  = S_SHIFT;
              end
            end
`ifdef RR_SHI_CTRL_STRIP_EN
            2'b01: begin
              if (reg_zero) begin
                cmd_err_d = 1'b1;
                done_d    = 1'b1;
              end else begin
                state_d = S_STRIP;
              end
            end
`endif
            2'b10: begin
              word_cnt_d = '0;
              state_d    = S_IDLE;
              done_d     = 1'b1;
            end
            default: begin
              cmd_err_d = 1'b1;
              done_d    = 1'b1;
            end
          endcase
        end
      end
      S_SHIFT: begin
        remain_d    = remain_q - 1'b1;
        shift_cnt_d = shift_cnt_q + 1'b1;
        if (remain_q == CNT_ONE) begin
          state_d = S_HOLD;
          done_d  = 1'b1;
        end
      end
      S_STRIP: begin
        if (strip_step) begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end else begin
          state_d = S_HOLD;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    reg_we     = 1'b0;
    reg_sel_rs = 1'b0;
    reg_din    = '0;
    if (load_fire) begin
      reg_we  = 1'b1;
      reg_din = in_data;
    end else if ((state_q == S_SHIFT) || strip_step) begin
      reg_we     = 1'b1;
      reg_sel_rs = 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_shi_ctrl.sv
// Directed bench for rr_shi_ctrl; includes a behavioural model of the 256-bit shift register.
// Strip expectations follow RR_SHI_CTRL_STRIP_EN.
module tb_rr_shi_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_data = '0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic [7:0]   cmd_amt = '0;
  logic         reg_lsb, reg_zero;
  logic         reg_we, reg_sel_rs;
  logic [15:0]  reg_din;
  logic         busy, done, cmd_err;
  logic [7:0]   shift_cnt;
  logic [255:0] r_model = '0;
  int           n_pass = 0;
  int           n_total = 0;

  rr_shi_ctrl #(.WORDS(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_amt(cmd_amt),
    .reg_lsb(reg_lsb), .reg_zero(reg_zero),
    .reg_we(reg_we), .reg_sel_rs(reg_sel_rs), .reg_din(reg_din),
    .busy(busy), .done(done), .shift_cnt(shift_cnt), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // External register: word loads enter at the top, so the first word ends in the LSW.
  always @(posedge clk) begin
    if (reg_we) r_model <= reg_sel_rs ? (r_model >> 1) : {reg_din, r_model[255:16]};
  end
  assign reg_lsb  = r_model[0];
  assign reg_zero = (r_model == '0);

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},   256'(in_ready),   256'd1);
    chk({tag, "_cmd_ready"},  256'(cmd_ready),  256'd0);
    chk({tag, "_reg_we"},     256'(reg_we),     256'd0);
    chk({tag, "_reg_sel_rs"}, 256'(reg_sel_rs), 256'd0);
    chk({tag, "_reg_din"},    256'(reg_din),    256'd0);
    chk({tag, "_busy"},       256'(busy),       256'd0);
    chk({tag, "_done"},       256'(done),       256'd0);
    chk({tag, "_shift_cnt"},  256'(shift_cnt),  256'd0);
    chk({tag, "_cmd_err"},    256'(cmd_err),    256'd0);
  endtask

  task automatic load(input string tag, input logic [255:0] v, input int gap_after, input int gap_len);
    int good = 0;
    int gap_ok = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[16*i +: 16];
      #1;
      if (reg_we === 1'b1 && reg_sel_rs === 1'b0 && reg_din === v[16*i +: 16] &&
          in_ready === 1'b1 && cmd_ready === 1'b0) good++;
      if (i + 1 == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = 16'hdead;
          #1;
          if (reg_we === 1'b0 && reg_din === 16'h0 && in_ready === 1'b1 && busy === 1'b1) gap_ok++;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    chk({tag, "_word_writes"}, 256'(good), 256'd16);
    chk({tag, "_gap_idle"},    256'(gap_ok), 256'(gap_len));
    chk({tag, "_cmd_ready"},   256'(cmd_ready), 256'd1);
    chk({tag, "_in_ready"},    256'(in_ready), 256'd0);
    chk({tag, "_reg_we"},      256'(reg_we), 256'd0);
    chk({tag, "_contents"},    r_model, v);
    $display("load %s: 16 words, gap %0d cycles, reg=%h", tag, gap_len, r_model);
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] amt,
                         input int exp_lat, input int exp_shifts, input int exp_cnt,
                         input logic exp_err, input logic exp_ready);
    int lat = 0;
    int shifts = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    #1;
    chk({tag, "_accept"}, 256'(cmd_ready), 256'd1);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_amt   = '0;
      end
      #1;
      if (reg_we === 1'b1 && reg_sel_rs === 1'b1) shifts++;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_done_lat"},  256'(lat), 256'(exp_lat));
    chk({tag, "_shifts"},    256'(shifts), 256'(exp_shifts));
    chk({tag, "_shift_cnt"}, 256'(shift_cnt), 256'(exp_cnt));
    chk({tag, "_cmd_err"},   256'(cmd_err), 256'(exp_err));
    chk({tag, "_cmd_ready"}, 256'(cmd_ready), 256'(exp_ready));
    $display("cmd %s: op=%0d amt=%0d done@t+%0d shifts=%0d cnt=%0d err=%0d", tag, op, amt, lat,
             shifts, shift_cnt, cmd_err);
  endtask

  initial begin
    logic [255:0] v_seq;
    int ok;
    int seen_done;
    for (int i = 0; i < 16; i++) v_seq[16*i +: 16] = 16'(i + 1);

    @(negedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    load("nostall", v_seq, 0, 0);
    run_cmd("reload1", 2'b10, 8'd0, 1, 0, 0, 1'b0, 1'b0);
    chk("reload1_in_ready", 256'(in_ready), 256'd1);
    chk("reload1_busy", 256'(busy), 256'd0);
    load("stall", v_seq, 5, 3);

    run_cmd("reload2", 2'b10, 8'd0, 1, 0, 0, 1'b0, 1'b0);
    load("val20", 256'h20, 0, 0);
    run_cmd("shift5", 2'b00, 8'd5, 6, 5, 5, 1'b0, 1'b1);
    chk("shift5_reg", r_model, 256'h1);
    @(negedge clk);
    #1;
    chk("shift5_cnt_held", 256'(shift_cnt), 256'd5);
    chk("shift5_done_pulse", 256'(done), 256'd0);

    run_cmd("shift0", 2'b00, 8'd0, 1, 0, 0, 1'b0, 1'b1);
    run_cmd("illegal", 2'b11, 8'd0, 1, 0, 0, 1'b1, 1'b1);
    run_cmd("shift1", 2'b00, 8'd1, 2, 1, 1, 1'b0, 1'b1);
    chk("shift1_reg", r_model, 256'h0);
    run_cmd("strip_zero", 2'b01, 8'd0, 1, 0, 0, 1'b1, 1'b1);

    run_cmd("reload3", 2'b10, 8'd0, 1, 0, 0, 1'b0, 1'b0);
    load("val40", 256'h40, 0, 0);
`ifdef RR_SHI_CTRL_STRIP_EN
    run_cmd("strip6", 2'b01, 8'd0, 8, 6, 6, 1'b0, 1'b1);
    chk("strip6_reg", r_model, 256'h1);
    run_cmd("reload4", 2'b10, 8'd0, 1, 0, 0, 1'b0, 1'b0);
    load("msb", {1'b1, 255'd0}, 0, 0);
    run_cmd("strip255", 2'b01, 8'd0, 257, 255, 255, 1'b0, 1'b1);
    chk("strip255_reg", r_model, 256'h1);
`else
    run_cmd("strip_off", 2'b01, 8'd0, 1, 0, 0, 1'b1, 1'b1);
    chk("strip_off_reg", r_model, 256'h40);
`endif

    run_cmd("reload5", 2'b10, 8'd0, 1, 0, 0, 1'b0, 1'b0);
    load("pre_abort", v_seq, 0, 0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_amt   = 8'd10;
    #1;
    chk("abort_accept", 256'(cmd_ready), 256'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      #1;
    end
    chk("abort_we", 256'(reg_we), 256'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    seen_done = 0;
    repeat (2) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0) seen_done++;
    end
    @(negedge clk);
    rst_n     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_amt   = 8'd0;
    ok = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (cmd_ready === 1'b0 && reg_we === 1'b0 && busy === 1'b0) ok++;
      if (done !== 1'b0) seen_done++;
    end
    chk("abort_no_done", 256'(seen_done), 256'd0);
    chk("abort_cmd_refused", 256'(ok), 256'd4);
    cmd_valid = 1'b0;
    $display("reset abort during shift 3 of amt=10");
    load("post_reset", v_seq, 0, 0);
    run_cmd("post_reset_cmd", 2'b00, 8'd0, 1, 0, 0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
